// File: rtl/ttt_game_ctrl.sv
//------------------------------------------------------------------------------
// Module      : ttt_game_ctrl
// Description : Tic-tac-toe game sequencer. Owns the 9-cell board, enforces
//               turn order, rejects moves on occupied cells, judges win/draw
//               after every move and steps through MAIN/PLAY/CHECK/RESULT.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ttt_game_ctrl #(
   parameter int RESULT_HOLD = 3000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        key_valid,
   input  logic [3:0]  key_code,
   output logic [17:0] board,
   output logic        turn_o,
   output logic        in_main,
   output logic [1:0]  result,
   output logic [8:0]  win_line,
   output logic        bad_move,
   output logic [3:0]  move_count
);

   localparam int c_HOLD_W = $clog2(RESULT_HOLD);
   localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(RESULT_HOLD - 1);

   localparam logic [1:0] c_ST_MAIN   = 2'd0;
   localparam logic [1:0] c_ST_PLAY   = 2'd1;
   localparam logic [1:0] c_ST_CHECK  = 2'd2;
   localparam logic [1:0] c_ST_RESULT = 2'd3;

   // Cell masks of the 8 lines: 3 rows, 3 columns, 2 diagonals (bit i = cell i)
   localparam logic [8:0] c_LINES [0:7] = '{
      9'b000_000_111, 9'b000_111_000, 9'b111_000_000,
      9'b001_001_001, 9'b010_010_010, 9'b100_100_100,
      9'b100_010_001, 9'b001_010_100
   };

   logic [1:0]          state_q, state_d;
   logic [17:0]         board_q, board_d;
   logic                turn_q, turn_d;
   logic                in_main_q, in_main_d;
   logic [1:0]          result_q, result_d;
   logic [8:0]          win_line_q, win_line_d;
   logic                bad_move_q, bad_move_d;
   logic [3:0]          move_count_q, move_count_d;
   logic [c_HOLD_W-1:0] hold_q, hold_d;

   logic       w_key_start;
   logic       w_key_abort;
   logic       w_key_cell;
   logic [3:0] w_cell_idx;
   logic       w_cell_busy;
   logic [1:0] w_mark;
   logic [8:0] w_mine;
   logic [7:0] w_hit;
   logic [8:0] w_win_line;
   logic       w_win;

   assign w_key_start = key_valid && (key_code == 4'd10);
   assign w_key_abort = key_valid && (key_code == 4'd12);
   assign w_key_cell  = key_valid && (key_code >= 4'd1) && (key_code <= 4'd9);
   assign w_cell_idx  = key_code - 4'd1;

   // Mark of the player to move: X = 01, O = 10
   assign w_mark = turn_q ? 2'b10 : 2'b01;

   // Occupancy of the addressed cell
   always_comb begin
      w_cell_busy = 1'b0;
      for (int c = 0; c < 9; c++) begin
         if (w_cell_idx == 4'(c)) begin
            w_cell_busy = (board_q[2*c +: 2] != 2'b00);
         end
      end
   end

   generate
      for (genvar c = 0; c < 9; c++) begin : g_cell
         assign w_mine[c] = (board_q[2*c +: 2] == w_mark);
      end
      for (genvar l = 0; l < 8; l++) begin : g_line
         assign w_hit[l] = ((w_mine & c_LINES[l]) == c_LINES[l]);
      end
   endgenerate

   // Union of all lines completed by the mover (double lines are possible)
   always_comb begin
      w_win_line = 9'd0;
      for (int l = 0; l < 8; l++) begin
         if (w_hit[l]) begin
            w_win_line = w_win_line | c_LINES[l];
         end
      end
   end

   assign w_win = |w_hit;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= c_ST_MAIN;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decision
   always_comb begin
      state_d = state_q;
      case (state_q)
         c_ST_MAIN: begin
            if (w_key_start) state_d = c_ST_PLAY;
         end
         c_ST_PLAY: begin
            if (w_key_cell) begin
               if (!w_cell_busy) state_d = c_ST_CHECK;
            end else if (w_key_abort) begin
               state_d = c_ST_MAIN;
            end
         end
         c_ST_CHECK: begin
            if (w_win || (move_count_q == 4'd9)) state_d = c_ST_RESULT;
            else                                  state_d = c_ST_PLAY;
         end
         default: begin
            if (w_key_start || (hold_q == c_HOLD_LAST)) state_d = c_ST_MAIN;
         end
      endcase
   end

   // Datapath and output next values
   always_comb begin
      board_d      = board_q;
      turn_d       = turn_q;
      result_d     = result_q;
      win_line_d   = win_line_q;
      bad_move_d   = 1'b0;
      move_count_d = move_count_q;
      hold_d       = '0;
      case (state_q)
         c_ST_MAIN: begin
            if (w_key_start) begin
               board_d      = 18'd0;
               result_d     = 2'b00;
               win_line_d   = 9'd0;
               move_count_d = 4'd0;
               turn_d       = 1'b0;
            end
         end
         c_ST_PLAY: begin
            if (w_key_cell) begin
               if (w_cell_busy) begin
                  bad_move_d = 1'b1;
               end else begin
                  for (int c = 0; c < 9; c++) begin
                     if (w_cell_idx == 4'(c)) board_d[2*c +: 2] = w_mark;
                  end
                  move_count_d = move_count_q + 4'd1;
               end
            end else if (w_key_abort) begin
               board_d      = 18'd0;
               move_count_d = 4'd0;
               turn_d       = 1'b0;
            end
         end
         c_ST_CHECK: begin
            // A win takes priority over a full board
            if (w_win) begin
               result_d   = w_mark;
               win_line_d = w_win_line;
            end else if (move_count_q == 4'd9) begin
               result_d   = 2'b11;
            end else begin
               turn_d     = ~turn_q;
            end
         end
         default: begin
            if (state_d == c_ST_RESULT) hold_d = hold_q + c_HOLD_W'(1);
         end
      endcase
      in_main_d = (state_d == c_ST_MAIN);
   end

   // Registered outputs and hold counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         board_q      <= 18'd0;
         turn_q       <= 1'b0;
         in_main_q    <= 1'b1;
         result_q     <= 2'b00;
         win_line_q   <= 9'd0;
         bad_move_q   <= 1'b0;
         move_count_q <= 4'd0;
         hold_q       <= '0;
      end else begin
         board_q      <= board_d;
         turn_q       <= turn_d;
         in_main_q    <= in_main_d;
         result_q     <= result_d;
         win_line_q   <= win_line_d;
         bad_move_q   <= bad_move_d;
         move_count_q <= move_count_d;
         hold_q       <= hold_d;
      end
   end

   assign board      = board_q;
   assign turn_o     = turn_q;
   assign in_main    = in_main_q;
   assign result     = result_q;
   assign win_line   = win_line_q;
   assign bad_move   = bad_move_q;
   assign move_count = move_count_q;

endmodule

`default_nettype wire

// File: tb/tb_ttt_game_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_ttt_game_ctrl
// Description : Self-checking bench for ttt_game_ctrl: directed game scenarios
//               followed by random key traffic against a game-rules model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ttt_game_ctrl;

   localparam int H = 4;

   logic        clk;
   logic        rst;
   logic        key_valid;
   logic [3:0]  key_code;
   logic [17:0] board;
   logic        turn_o;
   logic        in_main;
   logic [1:0]  result;
   logic [8:0]  win_line;
   logic        bad_move;
   logic [3:0]  move_count;

   int checks   = 0;
   int failures = 0;

   ttt_game_ctrl #(.RESULT_HOLD(H)) dut (
      .clk        (clk),
      .rst        (rst),
      .key_valid  (key_valid),
      .key_code   (key_code),
      .board      (board),
      .turn_o     (turn_o),
      .in_main    (in_main),
      .result     (result),
      .win_line   (win_line),
      .bad_move   (bad_move),
      .move_count (move_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Game model: phase 0 = main menu, 1 = awaiting move, 2 = judging, 3 = showing result
   int         cells [9];
   int         phase;
   int         mover;     // 1 = X, 2 = O
   int         mres;
   logic [8:0] mwin;
   int         mbad;
   int         mcnt;
   int         mhold;
   int         lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                                '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

   task automatic model_reset();
      foreach (cells[i]) cells[i] = 0;
      phase = 0; mover = 1; mres = 0; mwin = '0; mbad = 0; mcnt = 0; mhold = 0;
   endtask

   function automatic logic [17:0] model_board();
      logic [17:0] b;
      b = '0;
      for (int i = 0; i < 9; i++) b[2*i +: 2] = 2'(cells[i]);
      return b;
   endfunction

   task automatic model_step(input logic v, input int c);
      logic [8:0] w;
      mbad = 0;
      case (phase)
         0: if (v && c == 10) begin
               foreach (cells[i]) cells[i] = 0;
               mres = 0; mwin = '0; mcnt = 0; mover = 1; phase = 1;
            end
         1: if (v && c >= 1 && c <= 9) begin
               if (cells[c-1] != 0) mbad = 1;
               else begin cells[c-1] = mover; mcnt++; phase = 2; end
            end else if (v && c == 12) begin
               foreach (cells[i]) cells[i] = 0;
               mcnt = 0; mover = 1; phase = 0;
            end
         2: begin
               w = '0;
               for (int l = 0; l < 8; l++)
                  if (cells[lines[l][0]] == mover && cells[lines[l][1]] == mover &&
                      cells[lines[l][2]] == mover) begin
                     w[lines[l][0]] = 1'b1; w[lines[l][1]] = 1'b1; w[lines[l][2]] = 1'b1;
                  end
               if (w != 0) begin mres = mover; mwin = w; phase = 3; mhold = 0; end
               else if (mcnt == 9) begin mres = 3; phase = 3; mhold = 0; end
               else begin mover = 3 - mover; phase = 1; end
            end
         default: if ((v && c == 10) || mhold == H - 1) phase = 0;
                  else mhold++;
      endcase
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("board",      32'(board),      32'(model_board()));
      chk("turn_o",     32'(turn_o),     32'(mover == 2));
      chk("in_main",    32'(in_main),    32'(phase == 0));
      chk("result",     32'(result),     32'(mres));
      chk("win_line",   32'(win_line),   32'(mwin));
      chk("bad_move",   32'(bad_move),   32'(mbad));
      chk("move_count", 32'(move_count), 32'(mcnt));
   endtask

   // One clock: drive at negedge, step model at posedge, compare at next negedge
   task automatic tick(input logic v, input int c);
      key_valid = v;
      key_code  = 4'(c);
      @(posedge clk);
      model_step(v, c);
      @(negedge clk);
      key_valid = 1'b0;
      check_all();
   endtask

   task automatic press(input int c, input int gap);
      tick(1'b1, c);
      repeat (gap) tick(1'b0, 0);
   endtask

   task automatic play(input int keys [9], input int n);
      for (int i = 0; i < n; i++) press(keys[i], 3);
   endtask

   initial begin
      int seq [9];
      rst = 1'b1; key_valid = 1'b0; key_code = 4'd0;
      model_reset();
      repeat (2) @(negedge clk);
      check_all();
      rst = 1'b0;
      tick(1'b0, 0);

      // Start and X row win: 1,4,2,5,3
      tick(1'b1, 10);
      chk("start_in_main", 32'(in_main), 32'd0);
      chk("start_board",   32'(board),   32'd0);
      seq = '{1, 4, 2, 5, 0, 0, 0, 0, 0};
      play(seq, 4);
      tick(1'b1, 3);
      chk("row_board", 32'(board), 32'(18'b00_00_00_00_10_10_01_01_01));
      tick(1'b0, 0);
      chk("row_result",   32'(result),     32'd1);
      chk("row_win_line", 32'(win_line),   32'(9'b000000111));
      chk("row_count",    32'(move_count), 32'd5);
      // Hold: RESULT for exactly H cycles after entry, result retained in MAIN
      repeat (H - 1) tick(1'b0, 0);
      chk("hold_not_yet", 32'(in_main), 32'd0);
      tick(1'b0, 0);
      chk("hold_exit",      32'(in_main), 32'd1);
      chk("hold_keep_res",  32'(result),  32'd1);

      // Occupied cell
      press(10, 1);
      press(5, 3);
      tick(1'b1, 5);
      chk("occ_bad",   32'(bad_move),   32'd1);
      chk("occ_turn",  32'(turn_o),     32'd1);
      chk("occ_count", 32'(move_count), 32'd1);
      tick(1'b0, 0);
      chk("occ_bad_low", 32'(bad_move), 32'd0);

      // Abort in PLAY
      tick(1'b1, 12);
      chk("abort_main",  32'(in_main), 32'd1);
      chk("abort_board", 32'(board),   32'd0);

      // Draw
      press(10, 1);
      seq = '{1, 2, 3, 5, 4, 6, 8, 7, 9};
      play(seq, 9);
      chk("draw_result", 32'(result),   32'd3);
      chk("draw_win",    32'(win_line), 32'd0);
      chk("draw_count",  32'(move_count), 32'd9);
      chk("draw_state",  32'(in_main),  32'd0);
      repeat (4) tick(1'b0, 0);

      // Win on the ninth move, early exit on key 10
      press(10, 1);
      seq = '{1, 2, 3, 5, 4, 6, 8, 9, 7};
      play(seq, 8);
      tick(1'b1, 7);
      tick(1'b0, 0);
      chk("win9_result", 32'(result),   32'd1);
      chk("win9_line",   32'(win_line), 32'(9'b001001001));
      tick(1'b1, 10);
      chk("early_exit",  32'(in_main),  32'd1);

      // Key during CHECK is dropped
      press(10, 0);
      tick(1'b1, 1);
      tick(1'b1, 2);
      tick(1'b0, 0);
      chk("drop_board", 32'(board), 32'd1);

      // Asynchronous reset mid-game, observed before the next edge
      rst = 1'b1;
      #1;
      model_reset();
      check_all();
      @(negedge clk);
      rst = 1'b0;
      tick(1'b0, 0);

      // Random traffic
      for (int n = 0; n < 4000; n++) begin
         int r;
         r = $urandom_range(0, 19);
         if (r < 7)       tick(1'b0, 0);
         else if (r < 17) tick(1'b1, $urandom_range(1, 9));
         else if (r < 19) tick(1'b1, 10);
         else             tick(1'b1, $urandom_range(0, 15));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
